// File: rtl/rv32_dmem_pkg.sv
// Shared constants for the RV32 data-memory responder: MMIO register offsets
// (decoded from address[4:0]) and STATUS register bit positions.
package rv32_dmem_pkg;

    localparam logic [4:0] TXDATA_OFS      = 5'h00;
    localparam logic [4:0] STATUS_OFS      = 5'h04;
    localparam logic [4:0] MTIME_LO_OFS    = 5'h08;
    localparam logic [4:0] MTIME_HI_OFS    = 5'h0C;
    localparam logic [4:0] MTIMECMP_LO_OFS = 5'h10;
    localparam logic [4:0] MTIMECMP_HI_OFS = 5'h14;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BAD   = 3;

    function automatic logic is_timer_ofs(input logic [4:0] ofs);
        return (ofs == MTIME_LO_OFS) || (ofs == MTIME_HI_OFS) ||
               (ofs == MTIMECMP_LO_OFS) || (ofs == MTIMECMP_HI_OFS);
    endfunction

endpackage

// File: rtl/rv32_tx_fifo.sv
// Circular transmit queue with wrap-bit pointers; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module rv32_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wptr_q, wptr_d;
    logic [PW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q[PW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; emptiness is tracked by
    // the pointers, and an unreset array maps onto plain RAM/register cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-port target for the RV32 single-cycle core: word RAM plus an MMIO window
// with a console TX queue and, when RV32_DMEM_TIMER_EN is defined, a 64-bit timer.
module rv32_dmem_responder
    import rv32_dmem_pkg::*;
#(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter int            DEPTH_WORDS = 1024,
    parameter logic [AW-1:0] MMIO_BASE   = 32'h1000_0000,
    parameter int            TXQ_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          timer_irq,
    output logic          err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [4:0]       ofs;
    logic [IDX_W-1:0] ram_idx;
    logic             mmio_sel, ram_sel, mmio_hit, bad_acc, mmio_wr;
    logic             txq_push, txq_pop, txq_full, txq_empty;
    logic             st_wr;
    logic             ovf_q, ovf_d;
    logic             bad_q, bad_d;
    logic [DW-1:0]    status_word;
    logic [DW-1:0]    timer_rdata;
    logic [DW-1:0]    mem_q [DEPTH_WORDS];

    assign ofs      = address[4:0];
    assign ram_idx  = address[IDX_W+1:2];
    assign mmio_sel = (address[AW-1:AW-4] == MMIO_BASE[AW-1:AW-4]);
    assign ram_sel  = !mmio_sel && (address[AW-1:IDX_W+2] == '0);
    // Timer offsets stay mapped even when the timer is compiled out.
    assign mmio_hit = mmio_sel && ((ofs == TXDATA_OFS) || (ofs == STATUS_OFS) || is_timer_ofs(ofs));
    assign bad_acc  = (MemRead || MemWrite) && !ram_sel && !mmio_hit;
    assign mmio_wr  = MemWrite && mmio_sel;
    assign txq_push = mmio_wr && (ofs == TXDATA_OFS);
    assign st_wr    = mmio_wr && (ofs == STATUS_OFS);
    assign txq_pop  = tx_valid && tx_ready;

    rv32_tx_fifo #(
        .WIDTH (8),
        .DEPTH (TXQ_DEPTH)
    ) u_txq (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (txq_push),
        .push_data_i (wdata[7:0]),
        .pop_i       (txq_pop),
        .full_o      (txq_full),
        .empty_o     (txq_empty),
        .head_o      (tx_data)
    );

    assign tx_valid = !txq_empty;
    assign err      = bad_q;

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    assign ovf_d = (txq_push && txq_full && !txq_pop) ? 1'b1 :
                   (st_wr && wdata[ST_OVF])           ? 1'b0 : ovf_q;
    assign bad_d = bad_acc                            ? 1'b1 :
                   (st_wr && wdata[ST_BAD])           ? 1'b0 : bad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            bad_q <= bad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) begin
            mem_q[ram_idx] <= wdata;
        end
    end

    always_comb begin
        status_word         = '0;
        status_word[ST_FULL]  = txq_full;
        status_word[ST_EMPTY] = txq_empty;
        status_word[ST_OVF]   = ovf_q;
        status_word[ST_BAD]   = bad_q;
    end

`ifdef RV32_DMEM_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q;

    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (mmio_wr) begin
            case (ofs)
                MTIME_LO_OFS:    mtime_d    = {mtime_q[63:32], wdata};
                MTIME_HI_OFS:    mtime_d    = {wdata, mtime_q[31:0]};
                MTIMECMP_LO_OFS: mtimecmp_d = {mtimecmp_q[63:32], wdata};
                MTIMECMP_HI_OFS: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    always_comb begin
        timer_rdata = '0;
        case (ofs)
            MTIME_LO_OFS:    timer_rdata = mtime_q[31:0];
            MTIME_HI_OFS:    timer_rdata = mtime_q[63:32];
            MTIMECMP_LO_OFS: timer_rdata = mtimecmp_q[31:0];
            MTIMECMP_HI_OFS: timer_rdata = mtimecmp_q[63:32];
            default: ;
        endcase
    end

    assign timer_irq = irq_q;
`else
    assign timer_rdata = '0;
    assign timer_irq   = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        rdata = '0;
        if (MemRead) begin
            if (ram_sel) begin
                rdata = mem_q[ram_idx];
            end else if (mmio_sel) begin
                if (ofs == STATUS_OFS) begin
                    rdata = status_word;
                end else if (is_timer_ofs(ofs)) begin
                    rdata = timer_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed self-checking bench for rv32_dmem_responder; timer checks are
// compiled in only when RV32_DMEM_TIMER_EN is defined.
module tb_rv32_dmem_responder;

    logic        clk;
    logic        reset_n;
    logic [31:0] address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;
    logic        err;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_TX  = 32'h1000_0000;
    localparam logic [31:0] A_ST  = 32'h1000_0004;

    rv32_dmem_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .wdata     (wdata),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address  = a;
        wdata    = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        address = a;
        MemRead = 1'b1;
        #1;
        check(tag, rdata, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        address  = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        wdata    = '0;
        tx_ready = 1'b0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_irq", timer_irq, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

`ifdef RV32_DMEM_TIMER_EN
        begin
            logic seen;
            seen = 1'b0;
            wr(32'h1000_0014, 32'h0);
            wr(32'h1000_0010, 32'd20);
            for (int i = 0; i < 100 && !seen; i++) begin
                address = 32'h1000_0008;
                MemRead = 1'b1;
                #1;
                if (rdata == 32'd20) begin
                    seen = 1'b1;
                end else begin
                    MemRead = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            MemRead = 1'b0;
            check("mtime_reach20", seen, 1);
            check("irq_low_at_20", timer_irq, 0);
            @(posedge clk);
            #1;
            check("irq_high_after", timer_irq, 1);
            wr(32'h1000_000C, 32'hFFFF_FFFF);
            wr(32'h1000_0008, 32'hFFFF_FFFF);
            rd_chk(32'h1000_0008, 32'hFFFF_FFFF, "mtime_lo_max");
            rd_chk(32'h1000_000C, 32'hFFFF_FFFF, "mtime_hi_max");
            @(posedge clk);
            #1;
            rd_chk(32'h1000_0008, 32'h0, "mtime_lo_wrap");
            rd_chk(32'h1000_000C, 32'h0, "mtime_hi_wrap");
            check("irq_at_wrap", timer_irq, 1);
            rd_chk(32'h1000_0014, 32'h0, "mtimecmp_hi_rd");
        end
`endif

        // RAM word write, then read through an unaligned byte address
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk(32'h0000_0013, 32'hDEAD_BEEF, "ram_rd");
        address  = 32'h0000_0010;
        wdata    = 32'h1;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        #1;
        check("ram_rw_old", rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        #1;
        check("ram_rw_new", rdata, 32'h1);
        MemRead = 1'b0;
        #1;
        check("rdata_idle", rdata, 0);
        wr(32'h0000_0FFC, 32'hA5A5_0001);
        rd_chk(32'h0000_0FFC, 32'hA5A5_0001, "ram_last_word");
        check("err_after_ram", err, 0);

        // Fill the queue with the sink stalled, then overflow it
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h41 + i);
        rd_chk(A_ST, 32'h1, "status_full");
        check("head_41", tx_data, 8'h41);
        rd_chk(A_TX, 32'h0, "txdata_rd0");
        wr(A_TX, 32'h45);
        rd_chk(A_ST, 32'h5, "status_ovf");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", tx_valid, 1);
            check("drain_byte", tx_data, 8'h41 + i);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        check("drained_valid", tx_valid, 0);
        check("drained_data", tx_data, 0);
        rd_chk(A_ST, 32'h6, "status_empty_ovf");
        wr(A_ST, 32'h4);
        rd_chk(A_ST, 32'h2, "status_ovf_clr");

        // Full queue: push and pop in the same cycle
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h50 + i);
        address  = A_TX;
        wdata    = 32'h54;
        MemWrite = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        rd_chk(A_ST, 32'h1, "pushpop_full");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_byte", tx_data, 8'h51 + i);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        check("pp_empty", tx_valid, 0);

        // Unmapped accesses
        address = 32'h2000_0000;
        MemRead = 1'b1;
        #1;
        check("unmapped_rdata", rdata, 0);
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        check("err_set", err, 1);
        rd_chk(A_ST, 32'hA, "status_bad");
        wr(A_ST, 32'h8);
        check("err_clr", err, 0);
        address = 32'h0000_1000;
        MemRead = 1'b1;
        #1;
        check("beyond_ram_rdata", rdata, 0);
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        check("beyond_ram_err", err, 1);
        wr(A_ST, 32'h8);
        check("err_clr2", err, 0);
        wr(32'h1000_0018, 32'h1234);
        check("bad_mmio_ofs_err", err, 1);
        wr(A_ST, 32'h8);
        check("err_clr3", err, 0);

`ifndef RV32_DMEM_TIMER_EN
        address = 32'h1000_0008;
        MemRead = 1'b1;
        #1;
        check("notimer_rd", rdata, 0);
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        check("notimer_err", err, 0);
        wr(32'h1000_0010, 32'h5);
        rd_chk(32'h1000_0010, 32'h0, "notimer_wr_ign");
        check("notimer_err2", err, 0);
        check("notimer_irq", timer_irq, 0);
`endif

        // Asynchronous reset flushes the queue mid-cycle
        wr(A_TX, 32'h77);
        check("pre_rst_valid", tx_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_data", tx_data, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("post_rst_irq", timer_irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
